// File: rtl/maze_pkg.sv
// Shared definitions for the maze player stage and the display stage that
// reuses the cell lookup.
package maze_pkg;

    // Largest maze edge and the flattened bitmap size that goes with it.
    localparam int MAX_N     = 19;
    localparam int MAP_BITS  = MAX_N * MAX_N;

    // Row and column of the start cell after a map load.
    localparam int START_POS = 1;

    // Game states. IDLE: no valid map. READY: waiting for a button.
    // CHECK: target cell being looked up. WIN: exit reached.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        CHECK = 2'd2,
        WIN   = 2'd3
    } state_t;

    // Move directions, listed in descending priority.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // A maze edge is usable when it is odd and within 3..MAX_N.
    function automatic logic num_valid(input logic [4:0] n);
        return n[0] && (n >= 5'd3) && (n <= 5'(MAX_N));
    endfunction

endpackage

// File: rtl/maze_cell_lookup.sv
// Combinational cell query: is (row, col) a path cell of an N x N maze, and
// does it lie outside the walkable interior (border ring or beyond).
module maze_cell_lookup
    import maze_pkg::*;
(
    input  logic [MAP_BITS-1:0] map,
    input  logic [4:0]          n,
    input  logic [4:0]          row,
    input  logic [4:0]          col,
    output logic                is_path,
    output logic                off_limits
);

    logic [4:0] lim;
    logic [8:0] idx;

    // Border test first; the bitmap is only consulted for interior cells so
    // the index can never run past the end of the map.
    always_comb begin
        lim        = n - 5'd1;
        off_limits = (row == 5'd0) || (col == 5'd0) || (row >= lim) || (col >= lim);
        idx        = ({4'd0, row} * {4'd0, n}) + {4'd0, col};
        is_path    = 1'b0;
        if (!off_limits) begin
            is_path = map[idx];
        end
    end

endmodule

// File: rtl/maze_player_ctrl.sv
// Player movement and game state: snapshots a generated maze, walks the
// player on button pulses with wall rejection, and tracks steps, time and win.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic                clk,
    input  logic                rst_sys_n,
    input  logic                map_load,
    input  logic [MAP_BITS-1:0] map_in,
    input  logic [4:0]          num_in,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                tick_1hz,
    output logic [4:0]          player_row,
    output logic [4:0]          player_col,
    output logic [CNT_W-1:0]    step_cnt,
    output logic [CNT_W-1:0]    game_time,
    output logic                active,
    output logic                win,
    output logic                bump,
    output logic [1:0]          state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: there is none; map_load, buttons and tick_1hz are
    // single-cycle pulses sampled on the rising edge. A pulse that arrives
    // while the FSM cannot use it is discarded, never held.

    state_t              state_q;
    state_t              state_d;
    logic [MAP_BITS-1:0] map_q;
    logic [4:0]          n_q;
    logic [4:0]          tr_q;
    logic [4:0]          tc_q;
    logic [4:0]          tr_d;
    logic [4:0]          tc_d;
    dir_t                dir;
    logic                move_req;
    logic                load_ok;
    logic                accept;
    logic                reject;
    logic                at_exit;
    logic                is_path;
    logic                off_limits;

    maze_cell_lookup u_lookup (
        .map        (map_q),
        .n          (n_q),
        .row        (tr_q),
        .col        (tc_q),
        .is_path    (is_path),
        .off_limits (off_limits)
    );

    // Pick one direction by priority and form the neighbouring target cell.
    always_comb begin
        move_req = btn_up | btn_down | btn_left | btn_right;
        dir      = DIR_RIGHT;
        if (btn_up) begin
            dir = DIR_UP;
        end else if (btn_down) begin
            dir = DIR_DOWN;
        end else if (btn_left) begin
            dir = DIR_LEFT;
        end
        tr_d = player_row;
        tc_d = player_col;
        case (dir)
            DIR_UP:    tr_d = player_row - 5'd1;
            DIR_DOWN:  tr_d = player_row + 5'd1;
            DIR_LEFT:  tc_d = player_col - 5'd1;
            default:   tc_d = player_col + 5'd1;
        endcase
    end

    // Next-state logic; a map load overrides anything else, including a
    // move still being checked.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        load_ok = num_valid(num_in);
        at_exit = (tr_q == (n_q - 5'd2)) && (tc_q == (n_q - 5'd2));
        if (map_load) begin
            state_d = load_ok ? READY : IDLE;
        end else begin
            case (state_q)
                READY: begin
                    if (move_req) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (off_limits || !is_path) begin
                        reject  = 1'b1;
                        state_d = READY;
                    end else begin
                        accept  = 1'b1;
                        state_d = at_exit ? WIN : READY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshot, position, target and counter registers.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            map_q      <= '0;
            n_q        <= '0;
            tr_q       <= '0;
            tc_q       <= '0;
            player_row <= '0;
            player_col <= '0;
            step_cnt   <= '0;
            game_time  <= '0;
            bump       <= 1'b0;
        end else if (map_load) begin
            bump      <= 1'b0;
            step_cnt  <= '0;
            game_time <= '0;
            if (load_ok) begin
                map_q      <= map_in;
                n_q        <= num_in;
                player_row <= 5'(START_POS);
                player_col <= 5'(START_POS);
            end else begin
                map_q      <= '0;
                n_q        <= '0;
                player_row <= '0;
                player_col <= '0;
            end
        end else begin
            bump <= reject;
            if ((state_q == READY) && move_req) begin
                tr_q <= tr_d;
                tc_q <= tc_d;
            end
            if (accept) begin
                player_row <= tr_q;
                player_col <= tc_q;
                if (step_cnt != CNT_MAX) begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
            // Uses active from before the edge, so the tick that coincides
            // with the winning move still counts.
            if (tick_1hz && active && (game_time != CNT_MAX)) begin
                game_time <= game_time + 1'b1;
            end
        end
    end

    assign active    = (state_q == READY) || (state_q == CHECK);
    assign win       = (state_q == WIN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Bench for maze_player_ctrl: directed scenarios plus randomized play checked
// against a rule-level reference model of the game.
module tb_maze_player_ctrl;
    import maze_pkg::*;

    logic         clk = 1'b0;
    logic         rst_sys_n;
    logic         map_load;
    logic [360:0] map_in;
    logic [4:0]   num_in;
    logic         btn_up, btn_down, btn_left, btn_right;
    logic         tick_1hz;
    logic [4:0]   player_row, player_col;
    logic [9:0]   step_cnt, game_time;
    logic         active, win, bump;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;

    // reference model: phase 0 no map, 1 waiting, 2 move pending, 3 won
    logic [360:0] m_map;
    int           m_n, m_row, m_col, m_steps, m_time, m_phase, m_tr, m_tc;
    bit           m_bump;

    logic [360:0] map5;
    logic [360:0] open_map;

    maze_player_ctrl #(.CNT_W(10)) dut (
        .clk        (clk),
        .rst_sys_n  (rst_sys_n),
        .map_load   (map_load),
        .map_in     (map_in),
        .num_in     (num_in),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .tick_1hz   (tick_1hz),
        .player_row (player_row),
        .player_col (player_col),
        .step_cnt   (step_cnt),
        .game_time  (game_time),
        .active     (active),
        .win        (win),
        .bump       (bump),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_map = '0; m_n = 0; m_row = 0; m_col = 0; m_steps = 0;
        m_time = 0; m_phase = 0; m_tr = 0; m_tc = 0; m_bump = 0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit l, input bit r,
                              input bit t, input bit ld, input logic [360:0] mp, input int num);
        bit was_active;
        bit ok;
        was_active = (m_phase == 1) || (m_phase == 2);
        m_bump = 0;
        if (ld) begin
            if (num >= 3 && num <= 19 && (num % 2) == 1) begin
                m_map = mp; m_n = num; m_row = 1; m_col = 1; m_phase = 1;
            end else begin
                m_map = '0; m_n = 0; m_row = 0; m_col = 0; m_phase = 0;
            end
            m_steps = 0; m_time = 0;
        end else begin
            if (t && was_active && m_time < 1023) m_time++;
            if (m_phase == 1 && (u || d || l || r)) begin
                m_tr = m_row; m_tc = m_col;
                if (u) m_tr--;
                else if (d) m_tr++;
                else if (l) m_tc--;
                else m_tc++;
                m_phase = 2;
            end else if (m_phase == 2) begin
                ok = (m_tr >= 1) && (m_tc >= 1) && (m_tr <= m_n - 2) && (m_tc <= m_n - 2);
                if (ok) ok = m_map[m_tr * m_n + m_tc];
                if (ok) begin
                    m_row = m_tr; m_col = m_tc;
                    if (m_steps < 1023) m_steps++;
                    m_phase = (m_row == m_n - 2 && m_col == m_n - 2) ? 3 : 1;
                end else begin
                    m_bump = 1;
                    m_phase = 1;
                end
            end
        end
    endtask

    // one clock of stimulus, entered and left on a falling edge
    task automatic run_cycle(input bit u, input bit d, input bit l, input bit r,
                             input bit t, input bit ld, input logic [360:0] mp, input logic [4:0] num);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        tick_1hz = t; map_load = ld; map_in = mp; num_in = num;
        @(posedge clk);
        model_step(u, d, l, r, t, ld, mp, int'(num));
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        tick_1hz = 0; map_load = 0;
    endtask

    task automatic idle();
        run_cycle(0, 0, 0, 0, 0, 0, map_in, num_in);
    endtask

    task automatic load(input logic [360:0] mp, input logic [4:0] num);
        run_cycle(0, 0, 0, 0, 0, 1, mp, num);
    endtask

    task automatic test_reset();
        rst_sys_n = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        tick_1hz = 0; map_load = 0; map_in = '0; num_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({player_row, player_col, step_cnt, game_time, active, win, bump, state_dbg} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: row=%0d col=%0d steps=%0d time=%0d act=%b win=%b bump=%b st=%0d, required all 0",
                     player_row, player_col, step_cnt, game_time, active, win, bump, state_dbg);
        end
        rst_sys_n = 1;
        run_cycle(0, 0, 0, 1, 1, 0, '0, 5'd0);
        idle();
        checks++;
        if (active !== 1'b0 || player_col !== 5'd0 || game_time !== 10'd0) begin
            failures++;
            $display("FAIL idle_ignores_btn: act=%b col=%0d time=%0d, required 0 0 0", active, player_col, game_time);
        end
    endtask

    task automatic test_walk();
        load(map5, 5'd5);
        checks++;
        if (player_row !== 5'd1 || player_col !== 5'd1 || active !== 1'b1 || step_cnt !== 10'd0) begin
            failures++;
            $display("FAIL load_start: pos=(%0d,%0d) act=%b steps=%0d, required (1,1) 1 0", player_row, player_col, active, step_cnt);
        end
        run_cycle(0, 0, 0, 1, 0, 0, map5, 5'd5);
        checks++;
        if (state_dbg !== 2'd2 || player_col !== 5'd1) begin
            failures++;
            $display("FAIL move_latency: st=%0d col=%0d, required 2 1", state_dbg, player_col);
        end
        idle();
        checks++;
        if (player_row !== 5'd1 || player_col !== 5'd2 || step_cnt !== 10'd1 || bump !== 1'b0) begin
            failures++;
            $display("FAIL right1: pos=(%0d,%0d) steps=%0d bump=%b, required (1,2) 1 0", player_row, player_col, step_cnt, bump);
        end
        run_cycle(0, 0, 0, 1, 0, 0, map5, 5'd5);
        idle();
        checks++;
        if (player_row !== 5'd1 || player_col !== 5'd3 || step_cnt !== 10'd2 || bump !== 1'b0) begin
            failures++;
            $display("FAIL right2: pos=(%0d,%0d) steps=%0d bump=%b, required (1,3) 2 0", player_row, player_col, step_cnt, bump);
        end
    endtask

    task automatic test_bump_and_win();
        run_cycle(1, 0, 0, 0, 0, 0, map5, 5'd5);
        idle();
        checks++;
        if (bump !== 1'b1 || player_row !== 5'd1 || player_col !== 5'd3 || step_cnt !== 10'd2) begin
            failures++;
            $display("FAIL bump_up: bump=%b pos=(%0d,%0d) steps=%0d, required 1 (1,3) 2", bump, player_row, player_col, step_cnt);
        end
        idle();
        checks++;
        if (bump !== 1'b0) begin
            failures++;
            $display("FAIL bump_pulse: bump=%b, required 0", bump);
        end
        run_cycle(0, 1, 0, 0, 0, 0, map5, 5'd5);
        idle();
        run_cycle(0, 1, 0, 0, 0, 0, map5, 5'd5);
        run_cycle(0, 0, 0, 0, 1, 0, map5, 5'd5);
        checks++;
        if (player_row !== 5'd3 || player_col !== 5'd3 || win !== 1'b1 || active !== 1'b0 || step_cnt !== 10'd4) begin
            failures++;
            $display("FAIL win_reach: pos=(%0d,%0d) win=%b act=%b steps=%0d, required (3,3) 1 0 4",
                     player_row, player_col, win, active, step_cnt);
        end
        checks++;
        if (game_time !== 10'd1) begin
            failures++;
            $display("FAIL tick_on_win: time=%0d, required 1", game_time);
        end
        run_cycle(1, 0, 1, 0, 1, 0, map5, 5'd5);
        idle();
        checks++;
        if (player_row !== 5'd3 || player_col !== 5'd3 || win !== 1'b1 || game_time !== 10'd1 || step_cnt !== 10'd4) begin
            failures++;
            $display("FAIL win_frozen: pos=(%0d,%0d) win=%b time=%0d steps=%0d, required (3,3) 1 1 4",
                     player_row, player_col, win, game_time, step_cnt);
        end
    endtask

    task automatic test_priority();
        load(open_map, 5'd7);
        run_cycle(0, 1, 0, 0, 0, 0, open_map, 5'd7);
        idle();
        run_cycle(1, 0, 1, 0, 0, 0, open_map, 5'd7);
        idle();
        checks++;
        if (player_row !== 5'd1 || player_col !== 5'd1 || step_cnt !== 10'd2) begin
            failures++;
            $display("FAIL up_priority: pos=(%0d,%0d) steps=%0d, required (1,1) 2", player_row, player_col, step_cnt);
        end
    endtask

    task automatic test_drop_and_abort();
        run_cycle(0, 0, 0, 1, 0, 0, open_map, 5'd7);
        run_cycle(0, 1, 0, 0, 0, 0, open_map, 5'd7);
        idle();
        checks++;
        if (player_row !== 5'd1 || player_col !== 5'd2 || step_cnt !== 10'd3) begin
            failures++;
            $display("FAIL check_drop: pos=(%0d,%0d) steps=%0d, required (1,2) 3", player_row, player_col, step_cnt);
        end
        run_cycle(0, 0, 0, 1, 0, 0, open_map, 5'd7);
        load(open_map, 5'd7);
        idle();
        checks++;
        if (player_row !== 5'd1 || player_col !== 5'd1 || step_cnt !== 10'd0 || bump !== 1'b0 || active !== 1'b1) begin
            failures++;
            $display("FAIL load_abort: pos=(%0d,%0d) steps=%0d bump=%b act=%b, required (1,1) 0 0 1",
                     player_row, player_col, step_cnt, bump, active);
        end
    endtask

    task automatic test_bad_num();
        logic [4:0] bad [2];
        bad[0] = 5'd4;
        bad[1] = 5'd21;
        for (int i = 0; i < 2; i++) begin
            load(open_map, bad[i]);
            run_cycle(0, 1, 0, 0, 1, 0, open_map, bad[i]);
            idle();
            checks++;
            if (active !== 1'b0 || player_row !== 5'd0 || player_col !== 5'd0 || game_time !== 10'd0 || state_dbg !== 2'd0) begin
                failures++;
                $display("FAIL bad_num_%0d: act=%b pos=(%0d,%0d) time=%0d st=%0d, required 0 (0,0) 0 0",
                         bad[i], active, player_row, player_col, game_time, state_dbg);
            end
        end
    endtask

    task automatic test_time_sat();
        load(open_map, 5'd9);
        for (int i = 0; i < 500; i++) run_cycle(0, 0, 0, 0, 1, 0, open_map, 5'd9);
        checks++;
        if (game_time !== 10'd500) begin
            failures++;
            $display("FAIL time_count: time=%0d, required 500", game_time);
        end
        for (int i = 0; i < 600; i++) run_cycle(0, 0, 0, 0, 1, 0, open_map, 5'd9);
        checks++;
        if (game_time !== 10'd1023 || active !== 1'b1) begin
            failures++;
            $display("FAIL time_sat: time=%0d act=%b, required 1023 1", game_time, active);
        end
    endtask

    task automatic test_async_reset();
        load(open_map, 5'd7);
        run_cycle(0, 0, 0, 1, 1, 0, open_map, 5'd7);
        #2;
        rst_sys_n = 0;
        #1;
        model_reset();
        checks++;
        if ({player_row, player_col, step_cnt, game_time, active, win, bump, state_dbg} !== 35'd0) begin
            failures++;
            $display("FAIL async_reset: row=%0d col=%0d steps=%0d time=%0d act=%b win=%b bump=%b st=%0d, required all 0",
                     player_row, player_col, step_cnt, game_time, active, win, bump, state_dbg);
        end
        @(negedge clk);
        rst_sys_n = 1;
        run_cycle(0, 0, 0, 1, 0, 0, open_map, 5'd7);
        idle();
        checks++;
        if (active !== 1'b0 || player_col !== 5'd0 || step_cnt !== 10'd0) begin
            failures++;
            $display("FAIL post_reset_btn: act=%b col=%0d steps=%0d, required 0 0 0", active, player_col, step_cnt);
        end
    endtask

    task automatic test_random();
        logic [360:0] mp;
        logic [4:0]   num;
        logic [32:0]  exp_v;
        logic [32:0]  got_v;
        int           bad_seen;
        bad_seen = 0;
        mp  = '1;
        num = 5'd11;
        load(mp, num);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit ld;
            ld = ($urandom_range(0, 59) == 0);
            if (ld) begin
                for (int i = 0; i < 361; i++) mp[i] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 4) == 0) num = 5'($urandom_range(0, 31));
                else num = 5'(2 * $urandom_range(1, 9) + 1);
            end
            run_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, ld, mp, num);
            exp_v = {5'(m_row), 5'(m_col), 10'(m_steps), 10'(m_time),
                     (m_phase == 1) || (m_phase == 2), m_phase == 3, m_bump};
            got_v = {player_row, player_col, step_cnt, game_time, active, win, bump};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                if (bad_seen < 10)
                    $display("FAIL random_cycle_%0d: got row=%0d col=%0d steps=%0d time=%0d act=%b win=%b bump=%b, required row=%0d col=%0d steps=%0d time=%0d act=%b win=%b bump=%b",
                             cyc, player_row, player_col, step_cnt, game_time, active, win, bump,
                             exp_v[32:28], exp_v[27:23], exp_v[22:13], exp_v[12:3], exp_v[2], exp_v[1], exp_v[0]);
                bad_seen++;
            end
        end
    endtask

    initial begin
        map5 = '0;
        map5[6] = 1'b1; map5[7] = 1'b1; map5[8] = 1'b1; map5[13] = 1'b1; map5[18] = 1'b1;
        open_map = '1;
        test_reset();
        test_walk();
        test_bump_and_win();
        test_priority();
        test_drop_and_abort();
        test_bad_num();
        test_time_sat();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_player_ctrl.md
# maze_player_ctrl

Player-movement and game-state stage directly downstream of the maze generator. It snapshots the flattened maze bitmap and its size when the generator signals a new map, and holds the player at the start cell (1,1). It then steps the player on debounced direction pulses, rejecting moves into walls, and detects arrival at the exit cell (N-2,N-2). It feeds position, step count, elapsed time and win status to the display and scoring logic.

## Interface
- MAX_N, 19: largest supported maze edge; the map is MAX_N*MAX_N = 361 bits.
- CNT_W, 10: width of the step and time counters.
- clk  in  1  system clock.
- rst_sys_n  in  1  asynchronous, active-low reset.
- map_load  in  1  single-cycle pulse, asserted the cycle after the generator finishes; captures map_in and num_in.
- map_in  in  361  flattened maze, bit (r*N + c) = 1 for path, 0 for wall.
- num_in  in  5  maze edge N, odd, 3..19.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced single-cycle pulses.
- tick_1hz  in  1  single-cycle pulse, once per second.
- player_row, player_col  out  5 each  current position.
- step_cnt  out  CNT_W  accepted moves, saturating at 1023.
- game_time  out  CNT_W  seconds since load, saturating at 1023, frozen on win.
- active  out  1  a game is in progress (state READY or CHECK).
- win  out  1  level, high in state WIN.
- bump  out  1  single-cycle pulse when a move is rejected.

## Operation
- States:
  - IDLE: no valid map. Buttons are ignored.
  - READY: waiting for a button.
  - CHECK: looking up the target cell.
  - WIN: exit reached.
- Reset: all outputs 0, state IDLE, map snapshot cleared.
- Load handling (map_load=1, any state):
  - If num_in is in 3..19 and odd: snapshot map_in and num_in, set row=col=1, step_cnt=0, game_time=0, win=0, state READY.
  - Otherwise: state IDLE and outputs cleared.
  - map_load has priority over every other event in the same cycle, including an in-flight CHECK, which is aborted.
- Button handling in READY:
  - Direction priority when several pulse together: up > down > left > right. Only one move per cycle.
  - Target: up = row-1, down = row+1, left = col-1, right = col+1.
  - The target is registered and the state goes to CHECK.
  - Buttons arriving in CHECK, WIN or IDLE are dropped. There is no queue.
- CHECK:
  - The cell index is tr*N + tc, computed as 9-bit unsigned arithmetic. Max index 360, so no overflow.
  - Target is off-limits if tr or tc is 0, or tr or tc ≥ N-1. An off-limits target is rejected without any lookup.
  - Accept when the snapshot bit is 1: update position and increment step_cnt with saturation.
  - Reject when the bit is 0 or the target is off-limits: pulse bump and leave position unchanged.
  - Next state is READY, or WIN if the accepted position equals (N-2, N-2).
- game_time increments on tick_1hz only while active=1.

## Timing
- Button pulse in cycle t (state READY) → CHECK in t+1 → position, step_cnt and bump updated at the t+2 edge.
- win is asserted in the same cycle as the final position update.
- Minimum spacing between accepted moves is 2 cycles.
- map_load in cycle t: new outputs visible after the t edge; the first button is accepted in t+1.
- tick_1hz coinciding with the move that reaches WIN: the tick still counts, because the count uses active as it was before the edge.
- Asynchronous reset mid-CHECK: the move is lost and everything goes to reset values immediately.

## Structure
- Shared package maze_pkg holds:
  - MAX_N = 19 and MAP_BITS = 361.
  - The state enum (IDLE, READY, CHECK, WIN).
  - The direction enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT).
  - START_POS = 1.
- Sub-module maze_cell_lookup is combinational: it takes (map, N, row, col) and returns is_path and off_limits. The display stage reuses it.
- Top-level RTL: FSM, snapshot register, position registers, and two saturating counters.

## Test plan
- 5×5 map (bits 6,7,8,13,18 set), load, then btn_right twice → (1,2) then (1,3), step_cnt=2, no bump.
- Same map from (1,3): btn_up → bump pulse, position (1,3), step_cnt unchanged. Then btn_down ×2 → (3,3), win=1, active=0; further buttons ignored.
- btn_up and btn_left in the same cycle from (2,1) on an open map → moves to (1,1) only (up has priority).
- btn pulse during CHECK → dropped. map_load during CHECK → position (1,1), step_cnt 0, no bump.
- num_in=4 or num_in=21 on load → IDLE, active=0, buttons ignored. 1100 tick_1hz pulses while active → game_time saturates at 1023.
- Assert rst_sys_n low mid-game → all outputs 0 asynchronously. After release, buttons are ignored until map_load.
